// File: rtl/rtc_write_seq.sv
// RTC write-back sequencer: range-checks and snapshots six BCD fields on start,
// then writes them over the muxed address/data bus, PHASE_CYCLES clocks per bus phase.
module rtc_write_seq #(
  parameter int          PHASE_CYCLES = 4,
  parameter logic [7:0]  ADDR_SEC     = 8'h21,
  parameter logic [7:0]  ADDR_MIN     = 8'h22,
  parameter logic [7:0]  ADDR_HOUR    = 8'h23,
  parameter logic [7:0]  ADDR_DAY     = 8'h24,
  parameter logic [7:0]  ADDR_MON     = 8'h25,
  parameter logic [7:0]  ADDR_YEAR    = 8'h26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] sec_bcd,
  input  logic [7:0] min_bcd,
  input  logic [7:0] hour_bcd,
  input  logic [7:0] day_bcd,
  input  logic [7:0] mon_bcd,
  input  logic [7:0] year_bcd,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       rtc_cs_n,
  output logic       rtc_ale,
  output logic       rtc_wr_n,
  output logic       rtc_rd_n,
  output logic [7:0] rtc_ad,
  output logic       rtc_ad_oe
);

  localparam int             CW       = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(PHASE_CYCLES - 1);
  localparam logic [2:0]     IDX_LAST = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;
  typedef enum logic [2:0] {
    P_ASETUP, P_ALE, P_AHOLD, P_DSETUP, P_WR, P_DHOLD, P_GAP
  } phase_t;

  state_t        r_state, w_state_nx;
  phase_t        r_phase, w_phase_nx;
  logic [2:0]    r_idx,   w_idx_nx;
  logic [CW-1:0] r_cnt,   w_cnt_nx;

  logic [7:0] r_sec, r_min, r_hour, r_day, r_mon, r_year;

  logic       w_fields_ok;
  logic       w_accept;
  logic       w_reject;
  logic [7:0] w_addr;
  logic [7:0] w_data;

  logic       w_busy_nx, w_done_nx, w_err_nx;
  logic       w_cs_n_nx, w_ale_nx, w_wr_n_nx, w_oe_nx;
  logic [7:0] w_ad_nx;

  function automatic logic f_digits_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  // With both digits decimal, BCD bytes order the same as their numeric values.
  always_comb begin
    w_fields_ok = f_digits_ok(sec_bcd)  && f_digits_ok(min_bcd) &&
                  f_digits_ok(hour_bcd) && f_digits_ok(day_bcd) &&
                  f_digits_ok(mon_bcd)  && f_digits_ok(year_bcd) &&
                  (sec_bcd  <= 8'h59) && (min_bcd <= 8'h59) &&
                  (hour_bcd <= 8'h23) &&
                  (day_bcd  != 8'h00) && (day_bcd <= 8'h31) &&
                  (mon_bcd  != 8'h00) && (mon_bcd <= 8'h12);
  end

  assign w_accept = (r_state == S_IDLE) && start &&  w_fields_ok;
  assign w_reject = (r_state == S_IDLE) && start && !w_fields_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_phase <= P_ASETUP;
      r_idx   <= 3'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
      r_idx   <= w_idx_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_idx_nx   = r_idx;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nx = S_XFER;
          w_phase_nx = P_ASETUP;
          w_idx_nx   = 3'd0;
          w_cnt_nx   = '0;
        end
      end
      S_XFER: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nx = '0;
          if (r_phase == P_GAP) begin
            w_phase_nx = P_ASETUP;
            if (r_idx == IDX_LAST) begin
              w_state_nx = S_DONE;
              w_idx_nx   = 3'd0;
            end else begin
              w_idx_nx = r_idx + 3'd1;
            end
          end else begin
            w_phase_nx = phase_t'(r_phase + 3'd1);
          end
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sec  <= 8'h00;
      r_min  <= 8'h00;
      r_hour <= 8'h00;
      r_day  <= 8'h00;
      r_mon  <= 8'h00;
      r_year <= 8'h00;
    end else if (w_accept) begin
      r_sec  <= sec_bcd;
      r_min  <= min_bcd;
      r_hour <= hour_bcd;
      r_day  <= day_bcd;
      r_mon  <= mon_bcd;
      r_year <= year_bcd;
    end
  end

  // Data is only needed from P3 onward, by which time the snapshot is stable.
  always_comb begin
    w_addr = ADDR_SEC;
    w_data = r_sec;
    case (w_idx_nx)
      3'd0:    begin w_addr = ADDR_SEC;  w_data = r_sec;  end
      3'd1:    begin w_addr = ADDR_MIN;  w_data = r_min;  end
      3'd2:    begin w_addr = ADDR_HOUR; w_data = r_hour; end
      3'd3:    begin w_addr = ADDR_DAY;  w_data = r_day;  end
      3'd4:    begin w_addr = ADDR_MON;  w_data = r_mon;  end
      3'd5:    begin w_addr = ADDR_YEAR; w_data = r_year; end
      default: begin w_addr = ADDR_SEC;  w_data = r_sec;  end
    endcase
  end

  // Decoded from the next state so the registered pins line up with the FSM.
  always_comb begin
    w_busy_nx = 1'b0;
    w_done_nx = 1'b0;
    w_err_nx  = w_reject;
    w_cs_n_nx = 1'b1;
    w_ale_nx  = 1'b0;
    w_wr_n_nx = 1'b1;
    w_oe_nx   = 1'b0;
    w_ad_nx   = 8'h00;
    case (w_state_nx)
      S_XFER: begin
        w_busy_nx = 1'b1;
        w_cs_n_nx = 1'b0;
        w_oe_nx   = 1'b1;
        case (w_phase_nx)
          P_ASETUP: w_ad_nx = w_addr;
          P_ALE: begin
            w_ale_nx = 1'b1;
            w_ad_nx  = w_addr;
          end
          P_AHOLD:  w_ad_nx = w_addr;
          P_DSETUP: w_ad_nx = w_data;
          P_WR: begin
            w_wr_n_nx = 1'b0;
            w_ad_nx   = w_data;
          end
          P_DHOLD:  w_ad_nx = w_data;
          default: begin
            w_cs_n_nx = 1'b1;
            w_oe_nx   = 1'b0;
            w_ad_nx   = 8'h00;
          end
        endcase
      end
      S_DONE:  w_done_nx = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rtc_cs_n  <= 1'b1;
      rtc_ale   <= 1'b0;
      rtc_wr_n  <= 1'b1;
      rtc_ad    <= 8'h00;
      rtc_ad_oe <= 1'b0;
    end else begin
      busy      <= w_busy_nx;
      done      <= w_done_nx;
      err       <= w_err_nx;
      rtc_cs_n  <= w_cs_n_nx;
      rtc_ale   <= w_ale_nx;
      rtc_wr_n  <= w_wr_n_nx;
      rtc_ad    <= w_ad_nx;
      rtc_ad_oe <= w_oe_nx;
    end
  end

  // Write-only bus: the read strobe never asserts.
  assign rtc_rd_n = 1'b1;

endmodule

// File: tb/tb_rtc_write_seq.sv
// Scoreboard bench for rtc_write_seq: a field-level model queues expected bus writes,
// busy lengths and pulse counts; a bus monitor decodes the pins and compares.
module tb_rtc_write_seq;
  localparam int PC  = 2;
  localparam int SEQ = 42 * PC;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] sec, min_, hour, day, mon, year;
  logic       busy, done, err, rtc_cs_n, rtc_ale, rtc_wr_n, rtc_rd_n, rtc_ad_oe;
  logic [7:0] rtc_ad;

  always #5 clk = ~clk;

  rtc_write_seq #(.PHASE_CYCLES(PC)) dut (
    .clk(clk), .reset(reset), .start(start),
    .sec_bcd(sec), .min_bcd(min_), .hour_bcd(hour),
    .day_bcd(day), .mon_bcd(mon), .year_bcd(year),
    .busy(busy), .done(done), .err(err),
    .rtc_cs_n(rtc_cs_n), .rtc_ale(rtc_ale), .rtc_wr_n(rtc_wr_n),
    .rtc_rd_n(rtc_rd_n), .rtc_ad(rtc_ad), .rtc_ad_oe(rtc_ad_oe)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] q_wr[$];
  int          q_busy[$];
  int exp_done = 0, exp_err = 0, exp_cs = 0;
  int mon_done = 0, mon_err = 0, mon_cs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: fields packed {year,mon,day,hour,min,sec}, index 0 = sec.
  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int lo_of(input int i);
    return (i == 3 || i == 4) ? 1 : 0;
  endfunction

  function automatic int hi_of(input int i);
    case (i)
      0, 1:    return 59;
      2:       return 23;
      3:       return 31;
      4:       return 12;
      default: return 99;
    endcase
  endfunction

  function automatic bit fld_ok(input logic [7:0] b, input int i);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) &&
           (bcd_val(b) >= lo_of(i)) && (bcd_val(b) <= hi_of(i));
  endfunction

  function automatic bit model_ok(input logic [47:0] f);
    bit ok = 1'b1;
    for (int i = 0; i < 6; i++) if (!fld_ok(f[8*i +: 8], i)) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [47:0] rand_valid();
    logic [47:0] f;
    for (int i = 0; i < 6; i++) f[8*i +: 8] = to_bcd(int'($urandom_range(hi_of(i), lo_of(i))));
    return f;
  endfunction

  function automatic logic [47:0] rand_invalid();
    logic [47:0] f = rand_valid();
    int k = int'($urandom_range(5, 0));
    logic [7:0] b = 8'hFF;
    for (int t = 0; t < 200; t++) begin
      b = 8'($urandom());
      if (!fld_ok(b, k)) break;
    end
    if (fld_ok(b, k)) b = 8'hFF;
    f[8*k +: 8] = b;
    return f;
  endfunction

  task automatic apply(input logic [47:0] f);
    {year, mon, day, hour, min_, sec} = f;
  endtask

  task automatic push_writes(input logic [47:0] f, input int nwr);
    for (int i = 0; i < nwr; i++) q_wr.push_back({8'(8'h21 + i), f[8*i +: 8]});
  endtask

  task automatic push_full(input logic [47:0] f);
    push_writes(f, 6);
    q_busy.push_back(SEQ);
    exp_done++;
    exp_cs += 6;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
  endtask

  task automatic send(input logic [47:0] f);
    bit ok;
    @(negedge clk);
    apply(f);
    start = 1'b1;
    ok = model_ok(f);
    if (ok) push_full(f);
    else    exp_err++;
    @(negedge clk);
    start = 1'b0;
    apply(48'({$urandom(), $urandom()}));
    if (ok) begin
      chk("busy_after_start", busy, 1);
      wait_done(SEQ + 10);
    end else begin
      chk("err_pulse", err, 1);
      chk("busy_rejected", busy, 0);
      @(negedge clk);
      chk("err_one_cycle", err, 0);
      chk("cs_idle_rejected", rtc_cs_n, 1);
    end
  endtask

  // Bus monitor
  initial begin
    logic       p_ale = 1'b0, p_wr_n = 1'b1, p_busy = 1'b0, p_cs_n = 1'b1;
    logic [7:0] cur_addr = 8'h00, cur_data = 8'h00;
    int         run = 0, wr_w = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        p_ale = 1'b0; p_wr_n = 1'b1; p_busy = 1'b0; p_cs_n = 1'b1;
        run = 0; wr_w = 0;
      end else begin
        chk("inv_ale_and_wr", rtc_ale && !rtc_wr_n, 0);
        if (!rtc_wr_n) chk("inv_wr_needs_cs_oe", {rtc_cs_n, rtc_ad_oe}, 2'b01);
        if (rtc_ale && !p_ale) cur_addr = rtc_ad;
        if (!rtc_wr_n && p_wr_n) begin
          cur_data = rtc_ad;
          wr_w = 0;
        end
        if (!rtc_wr_n) begin
          wr_w++;
          chk("ad_stable_in_wr", rtc_ad, cur_data);
        end
        if (rtc_wr_n && !p_wr_n) begin
          chk("wr_width", wr_w, PC);
          if (q_wr.size() == 0) chk("unexpected_write", {cur_addr, cur_data}, 0);
          else                  chk("write_addr_data", {cur_addr, cur_data}, q_wr.pop_front());
        end
        if (!rtc_cs_n && p_cs_n) mon_cs++;
        if (done) mon_done++;
        if (err)  mon_err++;
        if (busy) run++;
        if (!busy && p_busy) begin
          chk("done_at_busy_fall", done, 1);
          if (q_busy.size() == 0) chk("unexpected_busy_run", run, 0);
          else                    chk("busy_len", run, q_busy.pop_front());
          run = 0;
        end
        p_ale = rtc_ale; p_wr_n = rtc_wr_n; p_busy = busy; p_cs_n = rtc_cs_n;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [47:0] f1, f2;
    reset = 1'b1;
    start = 1'b0;
    apply(48'h0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cs_n", rtc_cs_n, 1);
    chk("rst_ale", rtc_ale, 0);
    chk("rst_wr_n", rtc_wr_n, 1);
    chk("rst_rd_n", rtc_rd_n, 1);
    chk("rst_ad", rtc_ad, 8'h00);
    chk("rst_ad_oe", rtc_ad_oe, 0);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_cs_n", rtc_cs_n, 1);
    chk("idle_wr_n", rtc_wr_n, 1);
    chk("idle_rd_n", rtc_rd_n, 1);
    chk("idle_ale", rtc_ale, 0);
    chk("idle_ad_oe", rtc_ad_oe, 0);
    chk("idle_busy", busy, 0);
    chk("idle_no_done", mon_done, 0);
    chk("idle_no_err", mon_err, 0);

    // Directed write of 13:30:45 31-12-24
    send({8'h24, 8'h12, 8'h31, 8'h13, 8'h30, 8'h45});

    // Range-check rejections
    send({8'h24, 8'h12, 8'h32, 8'h13, 8'h30, 8'h45});
    send({8'h24, 8'h00, 8'h31, 8'h13, 8'h30, 8'h45});
    send({8'h24, 8'h12, 8'h31, 8'h24, 8'h30, 8'h45});
    send({8'h24, 8'h12, 8'h31, 8'h13, 8'h30, 8'h5A});
    // Edge-of-range values that must be accepted
    send({8'h99, 8'h01, 8'h01, 8'h00, 8'h59, 8'h59});

    // Inputs scrambled and start re-pulsed during the third field
    f1 = rand_valid();
    @(negedge clk);
    apply(f1);
    start = 1'b1;
    push_full(f1);
    @(negedge clk);
    start = 1'b0;
    repeat (2 * 7 * PC + 5) @(negedge clk);
    chk("busy_mid_seq", busy, 1);
    apply(48'({$urandom(), $urandom()}));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    apply(48'({$urandom(), $urandom()}));
    wait_done(SEQ + 10);

    // Reset during the hour write strobe
    f1 = rand_valid();
    @(negedge clk);
    apply(f1);
    start = 1'b1;
    push_writes(f1, 2);
    exp_cs += 3;
    @(negedge clk);
    start = 1'b0;
    repeat ((2 * 7 + 4) * PC) @(negedge clk);
    chk("hour_wr_low", rtc_wr_n, 0);
    chk("hour_wr_data", rtc_ad, f1[23:16]);
    #1 reset = 1'b1;
    #1;
    chk("abort_wr_n", rtc_wr_n, 1);
    chk("abort_cs_n", rtc_cs_n, 1);
    chk("abort_ad_oe", rtc_ad_oe, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ale", rtc_ale, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_done", done, 0);
    send(rand_valid());

    // Randomized mix of accepted and rejected commits
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(9, 0) < 7) send(rand_valid());
      else                          send(rand_invalid());
    end

    // Back-to-back: start held high through DONE
    f1 = rand_valid();
    f2 = rand_valid();
    @(negedge clk);
    apply(f1);
    start = 1'b1;
    push_full(f1);
    @(negedge clk);
    chk("b2b_first_busy", busy, 1);
    apply(f2);
    push_full(f2);
    wait_done(SEQ + 10);
    @(negedge clk);
    chk("b2b_idle_gap", busy, 0);
    @(negedge clk);
    chk("b2b_second_busy", busy, 1);
    start = 1'b0;
    apply(48'({$urandom(), $urandom()}));
    wait_done(SEQ + 10);

    repeat (5) @(negedge clk);
    chk("writes_outstanding", q_wr.size(), 0);
    chk("busy_runs_outstanding", q_busy.size(), 0);
    chk("done_pulses", mon_done, exp_done);
    chk("err_pulses", mon_err, exp_err);
    chk("cs_assertions", mon_cs, exp_cs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rtc_write_seq.md
Name: rtc_write_seq

Overview:
Write-back sequencer for the real-time clock. It takes the BCD time/date fields edited by the up/down field counters and writes them to the RTC over the multiplexed address/data parallel bus. This is the write-side counterpart of the RTC read path that preloads those counters. It sits between the field counters and the RTC pins, and is triggered by a single commit strobe from the edit-mode controller.

Parameters:
PHASE_CYCLES, 4, clk cycles per bus phase (>=1)
ADDR_SEC, 8'h21, RTC register address for seconds
ADDR_MIN, 8'h22, RTC register address for minutes
ADDR_HOUR, 8'h23, RTC register address for hours
ADDR_DAY, 8'h24, RTC register address for day of month
ADDR_MON, 8'h25, RTC register address for month
ADDR_YEAR, 8'h26, RTC register address for year

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  commit request, sampled on rising clk edge
sec_bcd  input  8  seconds, BCD
min_bcd  input  8  minutes, BCD
hour_bcd  input  8  hours (24h), BCD
day_bcd  input  8  day of month, BCD
mon_bcd  input  8  month, BCD
year_bcd  input  8  year 00-99, BCD
busy  output  1  write sequence in progress
done  output  1  one-cycle pulse when the sequence completes
err  output  1  one-cycle pulse when start is rejected by the range check
rtc_cs_n  output  1  RTC chip select, active-low
rtc_ale  output  1  address latch strobe, active-high
rtc_wr_n  output  1  write strobe, active-low
rtc_rd_n  output  1  read strobe, held at 1
rtc_ad  output  8  multiplexed address/data value
rtc_ad_oe  output  1  bus drive enable for the top-level tristate

Behaviour:
- Reset (async) values:
  - busy=0, done=0, err=0
  - rtc_cs_n=1, rtc_ale=0, rtc_wr_n=1, rtc_rd_n=1
  - rtc_ad=8'h00, rtc_ad_oe=0
  - FSM in IDLE, field index 0
- Reset mid-sequence: all strobes go inactive immediately. The transaction is abandoned with no done pulse.
- IDLE, start=1 check: all six fields are range-checked combinationally.
  - Every nibble must be <=9.
  - sec and min: 00-59. hour: 00-23. day: 01-31. mon: 01-12. year: 00-99.
- Check fails: err=1 for one cycle. The FSM stays in IDLE and the bus is untouched.
- Check passes: all six fields are snapshotted into internal registers, busy=1 from the next cycle, and the FSM enters P0 with index 0. Input changes after the start edge have no effect.
- start while busy is ignored; no err is raised.
- Write order (index 0..5): sec, min, hour, day, mon, year, with the matching ADDR_*.
- Per-field phases, each exactly PHASE_CYCLES cycles, timed by a phase counter:
  - P0 ADDR_SETUP: cs_n=0, ad_oe=1, ad=addr.
  - P1 ALE: as P0 with ale=1.
  - P2 ADDR_HOLD: ale=0, ad=addr.
  - P3 DATA_SETUP: ad=data.
  - P4 WR: wr_n=0, ad=data.
  - P5 DATA_HOLD: wr_n=1, ad=data.
  - P6 GAP: cs_n=1, ad_oe=0, ad=00.
- After P6: if index<5, increment index and go to P0. If index=5, go to DONE.
- DONE (1 cycle): done=1, busy=0, then IDLE. A start in the DONE cycle is ignored.
- Sequence length: 42*PHASE_CYCLES cycles of busy=1.
  - Start sampled at edge N gives busy=1 after edges N..N+42*PHASE_CYCLES-1.
  - done=1 after edge N+42*PHASE_CYCLES.
- Strobe invariants:
  - ale and wr_n=0 are never both active.
  - wr_n=0 only while cs_n=0 and ad_oe=1.
  - ad is stable across every wr_n low window.
- All outputs are registered; no combinational path from inputs to rtc_* pins.

Test Plan:
- Reset then idle 20 cycles -> cs_n=1, wr_n=1, rd_n=1, ale=0, ad_oe=0, busy=0, no done/err pulses.
- PHASE_CYCLES=2, start with sec=45, min=30, hour=13, day=31, mon=12, year=24 -> exactly six ale pulses carrying addresses 21,22,23,24,25,26 in order. Six wr_n pulses of 2 cycles each carry data 45,30,13,31,12,24. busy is high for 84 cycles, then done pulses exactly once.
- Start with day=8'h32 (or mon=00, hour=24, sec=8'h5A) -> err is a 1-cycle pulse, busy stays 0, and no cs_n/ale/wr_n activity occurs.
- Change every input field and re-pulse start during the 3rd field write -> bus data still equals the original snapshot, no second sequence runs, and exactly one done pulse occurs.
- Assert reset during the P4 write of the hour field -> wr_n=1, cs_n=1, ad_oe=0 immediately, busy=0, no done. A subsequent start runs a full 6-field sequence.
- Back-to-back starts (start held high through DONE) -> the second sequence begins on the first IDLE cycle after done. Check every cycle of both runs with an assertion for the strobe invariants.
